// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame transmitter.
// The header is sent MSB first, so bit HDR_W-1 is the first bit on the line.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } state_t;

  localparam int HDR_W = 6;
  localparam logic [HDR_W-1:0] HDR_PATTERN = 6'b110101;

  function automatic logic hdr_bit(input logic [2:0] idx);
    return HDR_PATTERN[idx];
  endfunction

endpackage

// File: rtl/serial_frame_tx_piso.sv
// Parallel-in serial-out payload shifter.
// q_msb always shows the next payload bit to be sent; shifting discards it.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_msb
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= d;
    end else if (shift) begin
      r_data <= r_data << 1;
    end
  end

  assign q_msb = r_data[WIDTH-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: sends header 110101 then a latched payload, MSB first,
// advancing one bit per clk_en strobe. All outputs come straight from registers.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 start,
  input  logic [PAYLOAD_W-1:0] data_in,
  output logic                 ser_out,
  output logic                 ser_out_valid,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           cnt_out
);

  localparam int IDX_RAW = $clog2(PAYLOAD_W + 1);
  localparam int IDX_W   = (IDX_RAW < 3) ? 3 : IDX_RAW;
  localparam logic [IDX_W-1:0] HDR_LAST = IDX_W'(HDR_W - 1);
  localparam logic [IDX_W-1:0] PAY_LAST = IDX_W'(PAYLOAD_W - 1);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt, w_idx_dec;
  logic             r_ser, w_ser_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic             w_load, w_shift, w_q_msb;

  // The shifter is advanced as each payload bit is put on the line, so q_msb
  // is always the bit that the next strobe should present.
  piso_shift_reg #(.WIDTH(PAYLOAD_W)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .shift (w_shift),
    .d     (data_in),
    .q_msb (w_q_msb)
  );

  assign w_idx_dec = r_idx - IDX_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ser_nxt   = r_ser;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    unique case (r_state)
      IDLE: begin
        // A strobe coinciding with start is deliberately not consumed here.
        if (start) begin
          w_state_nxt = HEADER;
          w_idx_nxt   = HDR_LAST;
          w_ser_nxt   = HDR_PATTERN[HDR_W-1];
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_load      = 1'b1;
        end
      end
      HEADER: begin
        if (clk_en) begin
          if (r_idx == '0) begin
            w_state_nxt = PAYLOAD;
            w_idx_nxt   = PAY_LAST;
            w_ser_nxt   = w_q_msb;
            w_shift     = 1'b1;
          end else begin
            w_idx_nxt = w_idx_dec;
            w_ser_nxt = hdr_bit(w_idx_dec[2:0]);
          end
        end
      end
      PAYLOAD: begin
        if (clk_en) begin
          if (r_idx == '0) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_ser_nxt   = 1'b0;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_cnt_nxt   = r_cnt + 4'd1;
          end else begin
            w_idx_nxt = w_idx_dec;
            w_ser_nxt = w_q_msb;
            w_shift   = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_ser   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ser   <= w_ser_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign ser_out       = r_ser;
  assign ser_out_valid = r_valid;
  assign busy          = r_busy;
  assign done          = r_done;
  assign cnt_out       = r_cnt;

endmodule
